// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan controller and its BCM on-time timer.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    BLANK   = 3'd2,
    LATCH   = 3'd3,
    DISPLAY = 3'd4
  } state_t;

  // Channel field index within a packed {R,G,B} pixel; multiply by COLOR_BITS for the bit offset.
  localparam int R_FIELD = 2;
  localparam int G_FIELD = 1;
  localparam int B_FIELD = 0;

  function automatic int unsigned bcm_on_time(input int unsigned base_on, input int unsigned plane);
    return base_on << plane;
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// BCM on-time timer: owns the active-low OE window, open for BASE_ON<<plane cycles after load.
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int COLOR_BITS = 4,
  parameter int BASE_ON    = 8,
  parameter int PW         = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [PW-1:0] plane,
  output logic          done,
  output logic          oe
);

  localparam int CW = $clog2(BASE_ON << (COLOR_BITS - 1)) + 1;

  logic [CW-1:0] cnt;

  // done marks the last OE-active cycle so the controller leaves DISPLAY on the same edge OE closes.
  assign done = !oe && (cnt == CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      oe  <= 1'b1;
    end else if (load) begin
      cnt <= CW'(bcm_on_time(BASE_ON, 32'(plane)));
      oe  <= 1'b0;
    end else if (!oe) begin
      if (cnt == CW'(1)) begin
        cnt <= '0;
        oe  <= 1'b1;
      end else begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 dual-scan panel driver with BCM colour depth: fetch/shift a row plane, blank, latch, display.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS       = 64,
  parameter int ROW_BITS   = 4,
  parameter int COLOR_BITS = 4,
  parameter int BLANK_CYC  = 4,
  parameter int BASE_ON    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  output logic                      rd_en,
  output logic [ROW_BITS-1:0]       rd_row,
  output logic [$clog2(COLS)-1:0]   rd_col,
  input  logic [3*COLOR_BITS-1:0]   pix_top,
  input  logic [3*COLOR_BITS-1:0]   pix_bot,
  output logic [ROW_BITS-1:0]       row_addr,
  output logic                      R0,
  output logic                      G0,
  output logic                      B0,
  output logic                      R1,
  output logic                      G1,
  output logic                      B1,
  output logic                      clk_shft,
  output logic                      LAT,
  output logic                      OE,
  output logic                      frame_start,
  output logic                      busy,
  output state_t                    dbg_state
);

  localparam int CW   = $clog2(COLS);
  localparam int PW   = (COLOR_BITS > 1) ? $clog2(COLOR_BITS) : 1;
  localparam int SMAX = (2 * COLS + 2 > BLANK_CYC) ? 2 * COLS + 2 : BLANK_CYC;
  localparam int SW   = $clog2(SMAX);

  localparam logic [SW-1:0] SHIFT_LAST = SW'(2 * COLS + 1);
  localparam logic [SW-1:0] COL_SPAN   = SW'(2 * COLS);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYC - 1);

  state_t              state, state_n;
  logic [SW-1:0]       scnt, scnt_n;
  logic [ROW_BITS-1:0] row_q, row_n;
  logic [PW-1:0]       plane_q, plane_n;
  logic                load, done;
  logic                rd_en_n, sample_now;

  logic [COLOR_BITS-1:0] r_top, g_top, b_top, r_bot, g_bot, b_bot;

  assign r_top = pix_top[R_FIELD*COLOR_BITS +: COLOR_BITS];
  assign g_top = pix_top[G_FIELD*COLOR_BITS +: COLOR_BITS];
  assign b_top = pix_top[B_FIELD*COLOR_BITS +: COLOR_BITS];
  assign r_bot = pix_bot[R_FIELD*COLOR_BITS +: COLOR_BITS];
  assign g_bot = pix_bot[G_FIELD*COLOR_BITS +: COLOR_BITS];
  assign b_bot = pix_bot[B_FIELD*COLOR_BITS +: COLOR_BITS];

  assign dbg_state = state;

  hub75_bcm_timer #(
    .COLOR_BITS (COLOR_BITS),
    .BASE_ON    (BASE_ON),
    .PW         (PW)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .plane (plane_q),
    .done  (done),
    .oe    (OE)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      scnt    <= '0;
      row_q   <= '0;
      plane_q <= '0;
    end else begin
      state   <= state_n;
      scnt    <= scnt_n;
      row_q   <= row_n;
      plane_q <= plane_n;
    end
  end

  always_comb begin
    state_n = state;
    scnt_n  = scnt;
    row_n   = row_q;
    plane_n = plane_q;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_n = SHIFT;
          scnt_n  = '0;
        end
      end
      SHIFT: begin
        if (scnt == SHIFT_LAST) begin
          state_n = BLANK;
          scnt_n  = '0;
        end else begin
          scnt_n = scnt + SW'(1);
        end
      end
      BLANK: begin
        if (scnt == BLANK_LAST) begin
          state_n = LATCH;
          scnt_n  = '0;
        end else begin
          scnt_n = scnt + SW'(1);
        end
      end
      LATCH: begin
        state_n = DISPLAY;
        load    = 1'b1;
      end
      DISPLAY: begin
        if (done) begin
          // Advance is kept across a stop so a later enable resumes at the next plane.
          if (plane_q == PW'(COLOR_BITS - 1)) begin
            plane_n = '0;
            row_n   = row_q + ROW_BITS'(1);
          end else begin
            plane_n = plane_q + PW'(1);
          end
          state_n = enable ? SHIFT : IDLE;
          scnt_n  = '0;
        end
      end
      default: begin
        state_n = IDLE;
        scnt_n  = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  assign rd_en_n    = (state_n == SHIFT) && !scnt_n[0] && (scnt_n < COL_SPAN);
  assign sample_now = (state == SHIFT) && scnt[0] && (scnt < COL_SPAN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en       <= 1'b0;
      rd_row      <= '0;
      rd_col      <= '0;
      row_addr    <= '0;
      clk_shft    <= 1'b0;
      LAT         <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      {R0, G0, B0, R1, G1, B1} <= '0;
    end else begin
      rd_en       <= rd_en_n;
      clk_shft    <= (state_n == SHIFT) && scnt_n[0] && (scnt_n != SW'(1));
      LAT         <= (state_n == LATCH);
      busy        <= (state_n != IDLE);
      frame_start <= (state_n == SHIFT) && (scnt_n == '0) && (row_n == '0) && (plane_n == '0);
      if (rd_en_n) begin
        rd_col <= CW'(scnt_n >> 1);
        rd_row <= row_n;
      end
      if ((state == SHIFT) && (state_n == BLANK)) begin
        row_addr <= row_q;
      end
      if (state_n != SHIFT) begin
        {R0, G0, B0, R1, G1, B1} <= '0;
      end else if (sample_now) begin
        {R0, G0, B0} <= {r_top[plane_q], g_top[plane_q], b_top[plane_q]};
        {R1, G1, B1} <= {r_bot[plane_q], g_bot[plane_q], b_bot[plane_q]};
      end
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl: cycle-exact expected output trace built from the plane timing.
module tb_hub75_scan_ctrl;
  import hub75_pkg::*;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       rd_en;
  logic [0:0] rd_row;
  logic [1:0] rd_col;
  logic [5:0] pix_top;
  logic [5:0] pix_bot;
  logic [0:0] row_addr;
  logic       R0, G0, B0, R1, G1, B1;
  logic       clk_shft;
  logic       LAT;
  logic       OE;
  logic       frame_start;
  logic       busy;
  state_t     dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];
  logic        model_ra;

  hub75_scan_ctrl #(
    .COLS       (4),
    .ROW_BITS   (1),
    .COLOR_BITS (2),
    .BLANK_CYC  (2),
    .BASE_ON    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .rd_en       (rd_en),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .pix_top     (pix_top),
    .pix_bot     (pix_bot),
    .row_addr    (row_addr),
    .R0          (R0),
    .G0          (G0),
    .B0          (B0),
    .R1          (R1),
    .G1          (G1),
    .B1          (B1),
    .clk_shft    (clk_shft),
    .LAT         (LAT),
    .OE          (OE),
    .frame_start (frame_start),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Vector layout: {OE,LAT,clk_shft,rd_en,frame_start,busy,row_addr,R0,G0,B0,R1,G1,B1,rd_col,rd_row}
  function automatic logic [15:0] mk(input logic oe, input logic lat, input logic ck, input logic rd,
                                     input logic fs, input logic bz, input logic ra,
                                     input logic [5:0] col, input logic [1:0] rc, input logic rr);
    return {oe, lat, ck, rd, fs, bz, ra, col, rc, rr};
  endfunction

  function automatic logic [15:0] sample();
    return {OE, LAT, clk_shft, rd_en, frame_start, busy, row_addr[0], R0, G0, B0, R1, G1, B1,
            rd_en ? rd_col : 2'b00, rd_en ? rd_row[0] : 1'b0};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  // Expected trace of one plane: SHIFT(10) BLANK(2) LATCH(1) DISPLAY(2<<p)
  task automatic build_plane(input int r, input int p);
    logic [5:0] cb;
    logic       rd;
    cb = (p == 0) ? 6'b011_100 : 6'b101_010;
    for (int s = 0; s < 10; s++) begin
      rd = (s % 2 == 0) && (s < 8);
      exp_q.push_back(mk(1'b1, 1'b0, (s % 2 == 1) && (s >= 3), rd,
                         (s == 0) && (r == 0) && (p == 0), 1'b1, model_ra,
                         (s >= 2) ? cb : 6'b0, rd ? 2'(s / 2) : 2'b00, rd ? 1'(r) : 1'b0));
    end
    model_ra = 1'(r);
    for (int k = 0; k < 2; k++)
      exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_ra, 6'b0, 2'b00, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, model_ra, 6'b0, 2'b00, 1'b0));
    for (int k = 0; k < (2 << p); k++)
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, model_ra, 6'b0, 2'b00, 1'b0));
  endtask

  // drop_s: SHIFT cycle after which enable falls; abort_k: DISPLAY cycle at which rst is raised
  task automatic run_plane(input int r, input int p, input int drop_s, input int abort_k);
    logic [15:0] e;
    build_plane(r, p);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check($sformatf("r%0d_p%0d_c%0d", r, p, i), sample(), e);
      if (i == drop_s) enable = 1'b0;
      if (abort_k >= 0 && i == 13 + abort_k) begin
        rst = 1'b1;
        #1;
        check("rst_abort", sample(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0, 2'b00, 1'b0));
        check("rst_abort_state", 16'(dbg_state), 16'(IDLE));
        exp_q.delete();
        model_ra = 1'b0;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    pix_top  = 6'b10_01_11;
    pix_bot  = 6'b01_10_00;
    model_ra = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_out", sample(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0, 2'b00, 1'b0));
    check("reset_state", 16'(dbg_state), 16'(IDLE));
    check("reset_rd", {14'b0, rd_col}, 16'(rd_row));

    rst    = 1'b0;
    enable = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 2; r++)
        for (int p = 0; p < 2; p++)
          run_plane(r, p, -1, -1);

    run_plane(0, 0, -1, -1);
    run_plane(0, 1, -1, -1);
    run_plane(1, 0, 4, -1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("idle_%0d", k), sample(),
            mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, model_ra, 6'b0, 2'b00, 1'b0));
    end
    enable = 1'b1;
    run_plane(1, 1, -1, -1);
    run_plane(0, 0, -1, -1);
    run_plane(0, 1, -1, -1);
    run_plane(1, 0, -1, 0);

    @(negedge clk);
    check("rst_hold", sample(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b0, 2'b00, 1'b0));
    rst = 1'b0;
    run_plane(0, 0, -1, -1);
    run_plane(0, 1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
